// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// Module  : alu_core
// Purpose : 32-bit integer ALU for the execute stage. Performs add, sub, and,
//           or, xor and three shifts selected by i_ctrl. It also produces
//           zero, signed-less-than and unsigned-less-than flags, which branch
//           resolution uses.
//
// Build option:
//   ALU_OUTREG_EN  When defined, all outputs are registered on posedge i_clk
//                  (1-cycle latency) and cleared by i_rst. When undefined
//                  (default), the ALU is purely combinational and i_clk and
//                  i_rst are unused.
//
// Ports:
//   i_clk   in   1      clock (registered build only)
//   i_rst   in   1      asynchronous active-high reset (registered build only)
//   i_1     in   WIDTH  operand A (rs1)
//   i_2     in   WIDTH  operand B (rs2/imm); low $clog2(WIDTH) bits = shift amount
//   i_ctrl  in   3      operation select
//   o_1     out  WIDTH  result
//   o_zero  out  1      result is zero
//   o_neg   out  1      signed i_1 < i_2
//   o_negU  out  1      unsigned i_1 < i_2
// ---------------------------------------------------------------------------
module alu_core #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_1,
   input  logic [WIDTH-1:0] i_2,
   input  logic [2:0]       i_ctrl,
   output logic [WIDTH-1:0] o_1,
   output logic             o_zero,
   output logic             o_neg,
   output logic             o_negU
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SRA = 3'b101,
      OP_SRL = 3'b110,
      OP_SLL = 3'b111
   } aluOp_t;

   logic [SHW-1:0] w_shamt;
   logic [WIDTH:0] w_diff;
   logic           w_overflow;
   logic [WIDTH-1:0] w_result;
   logic           w_zero;
   logic           w_neg;
   logic           w_negU;

   assign w_shamt = i_2[SHW-1:0];

   // One (WIDTH+1)-bit subtract feeds both compare flags. The extra top bit is
   // the borrow, which is exactly the unsigned less-than. For the signed compare,
   // the sign of the difference is wrong whenever the subtract overflows. That
   // happens when the operands have opposite signs and the result sign differs
   // from i_1. XOR-ing with that overflow flag corrects extremes such as
   // 0x80000000 vs 0x7FFFFFFF.
   assign w_diff     = {1'b0, i_1} - {1'b0, i_2};
   assign w_overflow = (i_1[WIDTH-1] ^ i_2[WIDTH-1]) & (w_diff[WIDTH-1] ^ i_1[WIDTH-1]);
   assign w_negU     = w_diff[WIDTH];
   assign w_neg      = w_diff[WIDTH-1] ^ w_overflow;

   // Operation decode. Every code is defined. The subtract reuses the low bits
   // of the shared difference so there is only one subtractor.
   always_comb begin
      w_result = '0;
      case (aluOp_t'(i_ctrl))
         OP_ADD:  w_result = i_1 + i_2;
         OP_SUB:  w_result = w_diff[WIDTH-1:0];
         OP_AND:  w_result = i_1 & i_2;
         OP_OR:   w_result = i_1 | i_2;
         OP_XOR:  w_result = i_1 ^ i_2;
         OP_SRA:  w_result = $signed(i_1) >>> w_shamt;
         OP_SRL:  w_result = i_1 >> w_shamt;
         OP_SLL:  w_result = i_1 << w_shamt;
         default: w_result = '0;
      endcase
   end

   assign w_zero = (w_result == '0);

`ifdef ALU_OUTREG_EN
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_neg;
   logic             r_negU;

   // Output register stage. Reset forces a clean "zero result" state
   // immediately, discarding whatever was about to be captured.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
         r_negU   <= 1'b0;
      end else begin
         r_result <= w_result;
         r_zero   <= w_zero;
         r_neg    <= w_neg;
         r_negU   <= w_negU;
      end
   end

   assign o_1    = r_result;
   assign o_zero = r_zero;
   assign o_neg  = r_neg;
   assign o_negU = r_negU;
`else
   // In the combinational build the clock and reset ports exist only for a
   // uniform interface. Folding them into an unused net keeps them
   // intentionally dangling.
   logic w_unused;
   assign w_unused = ^{i_clk, i_rst};

   assign o_1    = w_result;
   assign o_zero = w_zero;
   assign o_neg  = w_neg;
   assign o_negU = w_negU;
`endif

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// Testbench for alu_core. Directed vectors with hand-computed expected
// results and flags. It works for both the combinational build and the
// ALU_OUTREG_EN registered build.
// ---------------------------------------------------------------------------
module tb_alu_core;

   logic        clock;
   logic        reset;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [2:0]  ctrl;
   logic [31:0] result;
   logic        zeroFlag;
   logic        negFlag;
   logic        negUFlag;

   int checkCount = 0;
   int passCount  = 0;

   alu_core #(.WIDTH(32)) dut (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_1    (opA),
      .i_2    (opB),
      .i_ctrl (ctrl),
      .o_1    (result),
      .o_zero (zeroFlag),
      .o_neg  (negFlag),
      .o_negU (negUFlag)
   );

   // Free-running clock, 10 ns period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive operands on a falling edge and wait until the result is due:
   // the next rising edge in the registered build, a short settle otherwise.
   task automatic applyStimulus(input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b);
      @(negedge clock);
      ctrl = c;
      opA  = a;
      opB  = b;
`ifdef ALU_OUTREG_EN
      @(posedge clock);
      #1;
`else
      #1;
`endif
   endtask

   task automatic runVector(input string tag, input logic [2:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expRes, input logic expZ,
                            input logic expNg, input logic expNu);
      applyStimulus(c, a, b);
      checkOutput({tag, ".res"},  result,              expRes);
      checkOutput({tag, ".zero"}, {31'b0, zeroFlag},   {31'b0, expZ});
      checkOutput({tag, ".neg"},  {31'b0, negFlag},    {31'b0, expNg});
      checkOutput({tag, ".negU"}, {31'b0, negUFlag},   {31'b0, expNu});
   endtask

   initial begin
      reset = 1'b1;
      ctrl  = 3'b000;
      opA   = 32'd2;
      opB   = 32'd2;
      #12;
`ifdef ALU_OUTREG_EN
      checkOutput("rst.res",  result,              32'h0);
      checkOutput("rst.zero", {31'b0, zeroFlag},   32'h1);
      checkOutput("rst.neg",  {31'b0, negFlag},    32'h0);
      checkOutput("rst.negU", {31'b0, negUFlag},   32'h0);
`else
      checkOutput("rstComb.res", result, 32'd4);
`endif
      @(negedge clock);
      reset = 1'b0;

      // Main function across all opcodes and the compare extremes
      runVector("add",      3'b000, 32'd2,         32'd2,         32'd4,         1'b0, 1'b0, 1'b0);
      runVector("sub",      3'b001, 32'd128,       32'd2,         32'd126,       1'b0, 1'b0, 1'b0);
      runVector("and",      3'b010, 32'd127,       32'd2,         32'd2,         1'b0, 1'b0, 1'b0);
      runVector("or",       3'b011, 32'd128,       32'd2,         32'd130,       1'b0, 1'b0, 1'b0);
      runVector("xor",      3'b100, 32'd6,         32'd10,        32'd12,        1'b0, 1'b1, 1'b1);
      runVector("sra",      3'b101, 32'h8000000F,  32'd2,         32'hE0000003,  1'b0, 1'b1, 1'b0);
      runVector("srl",      3'b110, 32'h8000000F,  32'd2,         32'h20000003,  1'b0, 1'b1, 1'b0);
      runVector("sll",      3'b111, 32'h8000000F,  32'd2,         32'h0000003C,  1'b0, 1'b1, 1'b0);
      runVector("subEq",    3'b001, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1'b0);
      runVector("addWrap",  3'b000, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b1, 1'b1, 1'b0);
      runVector("extMin",   3'b001, 32'h80000000,  32'h7FFFFFFF,  32'h00000001,  1'b0, 1'b1, 1'b0);
      runVector("extMax",   3'b010, 32'h7FFFFFFF,  32'h80000000,  32'h0,         1'b1, 1'b0, 1'b1);
      runVector("subNeg",   3'b001, 32'd2,         32'd5,         32'hFFFFFFFD,  1'b0, 1'b1, 1'b1);
      runVector("sll0",     3'b111, 32'h12345678,  32'h00000020,  32'h12345678,  1'b0, 1'b0, 1'b0);
      runVector("sraPos",   3'b101, 32'h70000000,  32'hFFFFFFE4,  32'h07000000,  1'b0, 1'b0, 1'b1);
      runVector("srl31",    3'b110, 32'hF0000000,  32'd31,        32'h00000001,  1'b0, 1'b1, 1'b0);

`ifdef ALU_OUTREG_EN
      // Latency: new inputs must not show before the next rising edge
      @(negedge clock);
      ctrl = 3'b000;
      opA  = 32'd100;
      opB  = 32'd23;
      #1;
      checkOutput("lat.before", result, 32'h00000001);
      @(posedge clock);
      #1;
      checkOutput("lat.after", result, 32'd123);

      // Mid-cycle reset pulse clears outputs without a clock edge
      @(negedge clock);
      opA = 32'd7;
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rstMid.res",  result,            32'h0);
      checkOutput("rstMid.zero", {31'b0, zeroFlag}, 32'h1);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("rstMid.cap", result, 32'd30);
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
